irq_ctrl: RTL and testbench
===========================

Name: irq_ctrl

Overview:
Interrupt controller sitting directly downstream of the timer unit. It consumes timer_interrupt and other peripheral interrupt lines, latches them as pending, and applies masking and fixed priority. It then issues a single vectored request to the instruction fetch stage, which redirects PC and returns an acknowledge. It saves the interrupted PC, blocks further requests while a handler runs, and is programmed through a small register port driven by the datapath.

Parameters:
NUM_IRQ, 4, number of interrupt sources; source 0 is wired to timer_interrupt; range 1..16.
VEC_BASE, 32'h00000100, handler vector base; vector = VEC_BASE + 4*id.

Ports:
clk  input  1  system clock
reset  input  1  synchronous active-high reset
irq_src  input  NUM_IRQ  raw interrupt lines; bit 0 = timer_interrupt
pc_in  input  32  current PC from instruction fetch
irq_ack  input  1  fetch has taken the redirect this cycle
irq_ret  input  1  return-from-handler instruction retired
wr_en  input  1  register write strobe
addr  input  2  register address for both write and read
wr_data  input  32  register write data
rd_data  output  32  register read data, combinational from addr
irq_req  output  1  request to fetch to redirect
irq_vector  output  32  handler address, valid while irq_req=1
epc  output  32  saved return PC, valid in ACTIVE
in_handler  output  1  high while state is ACTIVE

Behaviour:
- Reset is synchronous on the rising clk edge with reset=1. It clears: src_q, pending, mask, gie, state=IDLE, irq_req=0, irq_vector=0, epc=0, active_id=0, in_handler=0.
- Register map:
  - addr 0 CTRL, RW: bit31 = gie; bits[NUM_IRQ-1:0] = mask; other bits read 0.
  - addr 1 PEND: read returns pending; writing 1 to a bit clears it.
  - addr 2 STAT, RO: bit31 = in_handler; bits[3:0] = active_id.
  - addr 3 reserved: reads 0, writes ignored.
- Edge detect: src_q <= irq_src every cycle. A pending bit sets on any cycle where irq_src=1 and src_q=0.
  - If a set and a W1C clear hit the same bit in the same cycle, the set wins.
- Eligible = pending & mask, gated by gie. The selected id is the lowest-index eligible bit.
- State IDLE:
  - If eligible != 0, the next cycle enters REQ with irq_req=1, active_id=selected id, irq_vector=VEC_BASE+4*id.
  - These values are latched on entry and held stable throughout REQ, even if mask, gie or pending change.
- State REQ:
  - Holds irq_req=1 until irq_ack=1.
  - On the ack edge: clear pending[active_id], epc<=pc_in, irq_req<=0, state<=ACTIVE.
  - An ack in the same cycle REQ is entered is not possible, because irq_req is registered.
- State ACTIVE:
  - in_handler=1; no new requests (no nesting). Pending bits continue to accumulate.
  - irq_ret=1 moves to IDLE on the next cycle. A new request may issue one cycle after that.
- Ignored inputs: irq_ret in IDLE or REQ; irq_ack in IDLE or ACTIVE.
- Latency: a source rising edge sampled at edge n sets pending at n, and irq_req is high after edge n+1 when mask=1 and gie=1.
- Address arithmetic: irq_vector is a 32-bit add that wraps modulo 2^32.
- Reset mid-operation (in REQ or ACTIVE) returns to IDLE and discards all pending bits and epc.

Optional Feature:
IRQ_LEVEL_EN:
- When defined, sources are level-sensitive: pending = irq_src, with no latch and no edge detect. PEND writes are ignored, and the ack does not clear pending; software must quiet the source.
- When undefined, the edge-latched behaviour above applies.

Test Plan:
1. Basic timer request: reset, write CTRL=32'h80000001, pulse irq_src[0] 1 cycle -> irq_req=1 two edges later, irq_vector=32'h100; ack with pc_in=32'h40 -> epc=32'h40, in_handler=1, PEND=0.
2. Priority: mask=4'hF, gie=1, raise irq_src[2] and irq_src[1] together -> vector 32'h104 first; after ack and irq_ret -> second request with vector 32'h108.
3. Masking: mask=0, pulse irq_src[3] -> no irq_req, PEND reads 32'h8; then write mask bit3 -> irq_req next edge, vector 32'h10C.
4. No nesting: in ACTIVE, pulse irq_src[0] -> irq_req stays 0 and PEND bit0=1; irq_ret -> IDLE, then irq_req asserts.
5. Same-cycle set and clear: W1C PEND bit1 in the same cycle as an irq_src[1] rising edge -> PEND bit1=1.
6. Reset mid-REQ: while irq_req=1, assert reset 1 cycle -> irq_req=0, PEND=0, CTRL=0, epc=0.

Source files
------------

// File: rtl/irq_ctrl.sv
// Vectored interrupt controller: latches sources as pending, masks, picks the
// lowest eligible id and hands one request at a time to fetch. IRQ_LEVEL_EN selects level-sensitive sources.
module irq_ctrl #(
  parameter int          NUM_IRQ  = 4,
  parameter logic [31:0] VEC_BASE = 32'h0000_0100
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq_src,
  input  logic [31:0]        pc_in,
  input  logic               irq_ack,
  input  logic               irq_ret,
  input  logic               wr_en,
  input  logic [1:0]         addr,
  input  logic [31:0]        wr_data,
  output logic [31:0]        rd_data,
  output logic               irq_req,
  output logic [31:0]        irq_vector,
  output logic [31:0]        epc,
  output logic               in_handler,
  output logic [1:0]         state_dbg
);

  // Handshake: irq_req is held with a stable irq_vector until fetch pulses
  // irq_ack; the transfer completes on the first clock edge where both are high.
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, ACTIVE = 2'd2} state_t;

  state_t             state, state_n;
  logic [NUM_IRQ-1:0] pending;
  logic [NUM_IRQ-1:0] mask;
  logic [NUM_IRQ-1:0] eligible;
  logic               gie;
  logic [3:0]         active_id;
  logic [3:0]         sel_id;
  logic               any_elig;
  logic               unused_wr;

  assign unused_wr = ^wr_data[30:NUM_IRQ];

`ifdef IRQ_LEVEL_EN
  assign pending = irq_src;
`else
  logic [NUM_IRQ-1:0] src_q;
  logic [NUM_IRQ-1:0] set_bits;
  logic [NUM_IRQ-1:0] clr_bits;

  always_comb begin
    set_bits = irq_src & ~src_q;
    clr_bits = '0;
    if (wr_en && addr == 2'd1) clr_bits = wr_data[NUM_IRQ-1:0];
    if (state == REQ && irq_ack) clr_bits = clr_bits | (NUM_IRQ'(1) << active_id);
  end

  // A new edge overrides a clear landing on the same bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      src_q   <= '0;
      pending <= '0;
    end else begin
      src_q   <= irq_src;
      pending <= (pending & ~clr_bits) | set_bits;
    end
  end
`endif

  assign eligible = gie ? (pending & mask) : '0;
  assign any_elig = |eligible;

  always_comb begin
    sel_id = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (eligible[i]) sel_id = 4'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (any_elig) state_n = REQ;
      REQ:     if (irq_ack)  state_n = ACTIVE;
      ACTIVE:  if (irq_ret)  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mask       <= '0;
      gie        <= 1'b0;
      active_id  <= '0;
      irq_vector <= '0;
      epc        <= '0;
    end else begin
      if (wr_en && addr == 2'd0) begin
        mask <= wr_data[NUM_IRQ-1:0];
        gie  <= wr_data[31];
      end
      // Id and vector are captured once on entry so they stay stable in REQ.
      if (state == IDLE && any_elig) begin
        active_id  <= sel_id;
        irq_vector <= VEC_BASE + {26'd0, sel_id, 2'b00};
      end
      if (state == REQ && irq_ack) epc <= pc_in;
    end
  end

  assign irq_req    = (state == REQ);
  assign in_handler = (state == ACTIVE);
  assign state_dbg  = state;

  always_comb begin
    rd_data = '0;
    case (addr)
      2'd0: begin
        rd_data[NUM_IRQ-1:0] = mask;
        rd_data[31]          = gie;
      end
      2'd1: rd_data[NUM_IRQ-1:0] = pending;
      2'd2: begin
        rd_data[31]  = in_handler;
        rd_data[3:0] = active_id;
      end
      default: rd_data = '0;
    endcase
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a behavioural model.
module tb_irq_ctrl;
  localparam int          N    = 4;
  localparam logic [31:0] VBAS = 32'h0000_0100;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  irq_src;
  logic [31:0]   pc_in;
  logic          irq_ack;
  logic          irq_ret;
  logic          wr_en;
  logic [1:0]    addr;
  logic [31:0]   wr_data;
  logic [31:0]   rd_data;
  logic          irq_req;
  logic [31:0]   irq_vector;
  logic [31:0]   epc;
  logic          in_handler;
  logic [1:0]    state_dbg;

  int total = 0;
  int bad   = 0;

  irq_ctrl #(.NUM_IRQ(N), .VEC_BASE(VBAS)) dut (
    .clk(clk), .reset(reset), .irq_src(irq_src), .pc_in(pc_in),
    .irq_ack(irq_ack), .irq_ret(irq_ret), .wr_en(wr_en), .addr(addr),
    .wr_data(wr_data), .rd_data(rd_data), .irq_req(irq_req),
    .irq_vector(irq_vector), .epc(epc), .in_handler(in_handler),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // phase: 0 = waiting, 1 = requesting, 2 = handler running
  bit        m_valid = 0;
  bit        m_pend [N];
  bit        m_mask [N];
  bit        m_srcq [N];
  bit        m_gie;
  int        m_phase;
  int        m_id;
  logic [31:0] m_epc;

  always @(posedge clk) begin
    int  pick;
    bit  seen;
    bit  old_pend [N];
    if (reset) begin
      m_valid = 1;
      for (int i = 0; i < N; i++) begin
        m_pend[i] = 0; m_mask[i] = 0; m_srcq[i] = 0;
      end
      m_gie = 0; m_phase = 0; m_id = 0; m_epc = 0;
    end else if (m_valid) begin
      for (int i = 0; i < N; i++) old_pend[i] = m_pend[i];
      pick = 0; seen = 0;
      for (int i = 0; i < N; i++)
        if (!seen && m_gie && old_pend[i] && m_mask[i]) begin
          seen = 1; pick = i;
        end
      // pending: clears first, then fresh rising edges win
      for (int i = 0; i < N; i++) begin
        if (wr_en && addr == 2'd1 && wr_data[i]) m_pend[i] = 0;
        if (m_phase == 1 && irq_ack && m_id == i) m_pend[i] = 0;
        if (irq_src[i] && !m_srcq[i]) m_pend[i] = 1;
        m_srcq[i] = irq_src[i];
      end
      case (m_phase)
        0: if (seen) begin m_phase = 1; m_id = pick; end
        1: if (irq_ack) begin m_phase = 2; m_epc = pc_in; end
        default: if (irq_ret) m_phase = 0;
      endcase
      if (wr_en && addr == 2'd0) begin
        for (int i = 0; i < N; i++) m_mask[i] = wr_data[i];
        m_gie = wr_data[31];
      end
    end
  end

  function automatic logic [31:0] exp_rd(input logic [1:0] a);
    logic [31:0] r;
    r = 0;
    case (a)
      2'd0: begin
        for (int i = 0; i < N; i++) if (m_mask[i]) r = r + (32'd1 << i);
        if (m_gie) r = r + 32'h8000_0000;
      end
      2'd1: for (int i = 0; i < N; i++) if (m_pend[i]) r = r + (32'd1 << i);
      2'd2: r = (m_phase == 2 ? 32'h8000_0000 : 32'd0) + 32'(m_id);
      default: r = 0;
    endcase
    return r;
  endfunction

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (m_valid && !reset) begin
      total++;
      if (irq_req !== (m_phase == 1)) begin
        bad++; $display("FAIL cyc_irq_req act=%0h exp=%0h", irq_req, m_phase == 1);
      end
      total++;
      if (in_handler !== (m_phase == 2)) begin
        bad++; $display("FAIL cyc_in_handler act=%0h exp=%0h", in_handler, m_phase == 2);
      end
      total++;
      if (rd_data !== exp_rd(addr)) begin
        bad++; $display("FAIL cyc_rd_data addr=%0d act=%0h exp=%0h", addr, rd_data, exp_rd(addr));
      end
      if (m_phase == 1) begin
        total++;
        if (irq_vector !== VBAS + 32'(4 * m_id)) begin
          bad++; $display("FAIL cyc_vector act=%0h exp=%0h", irq_vector, VBAS + 32'(4 * m_id));
        end
      end
      if (m_phase == 2) begin
        total++;
        if (epc !== m_epc) begin
          bad++; $display("FAIL cyc_epc act=%0h exp=%0h", epc, m_epc);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(posedge clk); #1;
  endtask

  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic rd_chk(input string name, input logic [1:0] a, input logic [31:0] exp);
    addr = a; #1;
    lit(name, rd_data, exp);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    wr_en = 1; addr = a; wr_data = d;
    cycle();
    wr_en = 0; wr_data = 0;
  endtask

  task automatic pulse(input logic [N-1:0] s);
    irq_src = s; cycle(); irq_src = 0;
  endtask

  task automatic ack(input logic [31:0] pc);
    pc_in = pc; irq_ack = 1; cycle(); irq_ack = 0;
  endtask

  task automatic ret();
    irq_ret = 1; cycle(); irq_ret = 0;
  endtask

  initial begin
    reset = 1; irq_src = 0; pc_in = 0; irq_ack = 0; irq_ret = 0;
    wr_en = 0; addr = 0; wr_data = 0;
    cycle(); cycle();
    reset = 0;
    lit("rst_req", {31'd0, irq_req}, 32'd0);
    rd_chk("rst_ctrl", 2'd0, 32'd0);
    rd_chk("rst_pend", 2'd1, 32'd0);

    // basic timer request
    wr(2'd0, 32'h8000_0001);
    pulse(4'h1);
    rd_chk("t1_pend_set", 2'd1, 32'h1);
    lit("t1_req_lat", {31'd0, irq_req}, 32'd0);
    cycle();
    lit("t1_req", {31'd0, irq_req}, 32'd1);
    lit("t1_vec", irq_vector, 32'h100);
    ack(32'h40);
    lit("t1_epc", epc, 32'h40);
    lit("t1_inh", {31'd0, in_handler}, 32'd1);
    rd_chk("t1_pend_clr", 2'd1, 32'd0);
    rd_chk("t1_stat", 2'd2, 32'h8000_0000);
    ret();

    // priority
    wr(2'd0, 32'h8000_000F);
    pulse(4'h6);
    cycle();
    lit("t2_vec1", irq_vector, 32'h104);
    ack(32'h80);
    ret();
    lit("t2_idle", {31'd0, irq_req}, 32'd0);
    cycle();
    lit("t2_req2", {31'd0, irq_req}, 32'd1);
    lit("t2_vec2", irq_vector, 32'h108);
    ack(32'h84);
    ret();

    // masking
    wr(2'd0, 32'h8000_0000);
    pulse(4'h8);
    cycle(); cycle();
    lit("t3_noreq", {31'd0, irq_req}, 32'd0);
    rd_chk("t3_pend", 2'd1, 32'h8);
    wr(2'd0, 32'h8000_0008);
    cycle();
    lit("t3_req", {31'd0, irq_req}, 32'd1);
    lit("t3_vec", irq_vector, 32'h10C);
    ack(32'h90);
    ret();

    // no nesting
    wr(2'd0, 32'h8000_000F);
    pulse(4'h8);
    cycle();
    ack(32'h200);
    pulse(4'h1);
    cycle(); cycle();
    lit("t4_nonest", {31'd0, irq_req}, 32'd0);
    rd_chk("t4_pend", 2'd1, 32'h1);
    ret();
    lit("t4_idle", {31'd0, irq_req}, 32'd0);
    cycle();
    lit("t4_req", {31'd0, irq_req}, 32'd1);
    lit("t4_vec", irq_vector, 32'h100);
    ack(32'h300);
    ret();

    // same-cycle set and W1C
    wr(2'd0, 32'h8000_0000);
    pulse(4'h2);
    cycle();
    irq_src = 4'h2; wr_en = 1; addr = 2'd1; wr_data = 32'h2;
    cycle();
    irq_src = 0; wr_en = 0; wr_data = 0;
    rd_chk("t5_setwins", 2'd1, 32'h2);

    // reset mid-REQ
    wr(2'd0, 32'h8000_000F);
    cycle();
    lit("t6_req", {31'd0, irq_req}, 32'd1);
    lit("t6_epc_pre", epc, 32'h300);
    reset = 1; cycle(); reset = 0;
    lit("t6_req_rst", {31'd0, irq_req}, 32'd0);
    lit("t6_epc_rst", epc, 32'd0);
    rd_chk("t6_pend_rst", 2'd1, 32'd0);
    rd_chk("t6_ctrl_rst", 2'd0, 32'd0);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      irq_src = N'($urandom_range(0, 15));
      wr_en   = ($urandom_range(0, 7) == 0);
      addr    = 2'($urandom_range(0, 3));
      wr_data = $urandom;
      if (addr == 2'd0) wr_data[31] = ($urandom_range(0, 3) != 0);
      irq_ack = ($urandom_range(0, 2) == 0);
      irq_ret = ($urandom_range(0, 3) == 0);
      pc_in   = $urandom;
      reset   = ($urandom_range(0, 199) == 0);
      cycle();
    end
    reset = 0; wr_en = 0; irq_ack = 0; irq_ret = 0; irq_src = 0;
    cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
